irrigation_actuator_sequencer: RTL and testbench



---
 rtl/irrigation_actuator_sequencer.sv | 263 ++++++++++++++++++++++++++
 tb/tb_irrigation_actuator_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/irrigation_actuator_sequencer.sv
// Registered actuator stage for irrigation requests: dwell-timed pump/valve drive, error latch, alarm blink.
// Build option: define MAX_ON_TIMEOUT_EN to bound irrigation on time and enable the sticky timeout flag.
module irrigation_actuator_sequencer #(
  parameter int MIN_ON_CYCLES  = 8,
  parameter int MIN_OFF_CYCLES = 4,
  parameter int BLINK_HALF     = 4,
  parameter int MAX_ON_CYCLES  = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ve_req,
  input  logic       bs_req,
  input  logic       vs_req,
  input  logic       al_in,
  input  logic       e_in,
  input  logic       ack,
  output logic       ve_out,
  output logic       bs_out,
  output logic       vs_out,
  output logic       alarm_led,
  output logic       err_latched,
  output logic [2:0] state_o,
  output logic       timeout
);

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  localparam int CW = $clog2(max4(MIN_ON_CYCLES, MIN_OFF_CYCLES, BLINK_HALF, MAX_ON_CYCLES)) + 1;

  localparam logic [CW-1:0] ON_LAST   = CW'(MIN_ON_CYCLES - 1);
  localparam logic [CW-1:0] OFF_LAST  = CW'(MIN_OFF_CYCLES - 1);
  localparam logic [CW-1:0] BLINK_LEN = CW'(BLINK_HALF);
  localparam logic [CW-1:0] CNT_SAT   = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SPRINKLE = 3'd1,
    ST_DRIP     = 3'd2,
    ST_COOLDOWN = 3'd3,
    ST_FAULT    = 3'd4
  } state_t;

  state_t          state_r;
  state_t          state_next_s;
  logic [CW-1:0]   dwell_r;
  logic [CW-1:0]   dwell_next_s;
  logic            fault_s;
  logic            max_on_hit_s;
  logic            timeout_set_s;
  logic            err_r;
  logic            err_next_s;
  logic            ve_r;
  logic            ve_next_s;
  logic [CW-1:0]   ve_cnt_r;
  logic [CW-1:0]   ve_cnt_next_s;
  logic            led_r;
  logic            led_next_s;
  logic [CW-1:0]   blink_cnt_r;
  logic [CW-1:0]   blink_cnt_next_s;
  logic            bs_r;
  logic            vs_r;
  logic            timeout_r;

  assign fault_s = al_in | e_in | err_r;

`ifdef MAX_ON_TIMEOUT_EN
  localparam logic [CW-1:0] MAX_ON_LAST = CW'(MAX_ON_CYCLES - 1);
  assign max_on_hit_s = (dwell_r >= MAX_ON_LAST);
`else
  assign max_on_hit_s = 1'b0;
`endif

  // Irrigation mode selection; faults override every dwell requirement.
  always_comb begin
    state_next_s  = state_r;
    timeout_set_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (fault_s) begin
          state_next_s = ST_FAULT;
        end else if (timeout_r) begin
          state_next_s = ST_IDLE;
        end else if (bs_req) begin
          state_next_s = ST_SPRINKLE;
        end else if (vs_req) begin
          state_next_s = ST_DRIP;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SPRINKLE: begin
        if (fault_s) begin
          state_next_s = ST_FAULT;
        end else if (max_on_hit_s) begin
          state_next_s  = ST_COOLDOWN;
          timeout_set_s = 1'b1;
        end else if (!bs_req && (dwell_r >= ON_LAST)) begin
          state_next_s = ST_COOLDOWN;
        end else begin
          state_next_s = ST_SPRINKLE;
        end
      end
      ST_DRIP: begin
        if (fault_s) begin
          state_next_s = ST_FAULT;
        end else if (max_on_hit_s) begin
          state_next_s  = ST_COOLDOWN;
          timeout_set_s = 1'b1;
        end else if (!vs_req && (dwell_r >= ON_LAST)) begin
          state_next_s = ST_COOLDOWN;
        end else begin
          state_next_s = ST_DRIP;
        end
      end
      ST_COOLDOWN: begin
        if (fault_s) begin
          state_next_s = ST_FAULT;
        end else if (dwell_r >= OFF_LAST) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_COOLDOWN;
        end
      end
      ST_FAULT: begin
        if (!fault_s) begin
          state_next_s = ST_COOLDOWN;
        end else begin
          state_next_s = ST_FAULT;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Dwell counter restarts on every state change and saturates.
  always_comb begin
    dwell_next_s = dwell_r;
    if (state_next_s != state_r) begin
      dwell_next_s = CNT_ZERO;
    end else if (dwell_r != CNT_SAT) begin
      dwell_next_s = dwell_r + CNT_ONE;
    end else begin
      dwell_next_s = dwell_r;
    end
  end

  // Error latch: a simultaneous ack cannot clear an active error.
  always_comb begin
    err_next_s = err_r;
    if (e_in) begin
      err_next_s = 1'b1;
    end else if (ack) begin
      err_next_s = 1'b0;
    end else begin
      err_next_s = err_r;
    end
  end

  // Inlet valve with its own min on/off dwell; errors force it off at once.
  always_comb begin
    ve_next_s     = ve_r;
    ve_cnt_next_s = ve_cnt_r;
    if (e_in || err_r) begin
      ve_next_s = 1'b0;
    end else if (!ve_r) begin
      if (ve_req && (ve_cnt_r >= OFF_LAST)) begin
        ve_next_s = 1'b1;
      end else begin
        ve_next_s = 1'b0;
      end
    end else begin
      if (!ve_req && (ve_cnt_r >= ON_LAST)) begin
        ve_next_s = 1'b0;
      end else begin
        ve_next_s = 1'b1;
      end
    end
    if (ve_next_s != ve_r) begin
      ve_cnt_next_s = CNT_ZERO;
    end else if (ve_cnt_r != CNT_SAT) begin
      ve_cnt_next_s = ve_cnt_r + CNT_ONE;
    end else begin
      ve_cnt_next_s = ve_cnt_r;
    end
  end

  // Alarm indicator; blink_cnt of zero marks "not blinking" so the pattern restarts high.
  always_comb begin
    led_next_s       = 1'b0;
    blink_cnt_next_s = CNT_ZERO;
    if (err_next_s) begin
      led_next_s       = 1'b1;
      blink_cnt_next_s = CNT_ZERO;
    end else if (al_in) begin
      if (blink_cnt_r == CNT_ZERO) begin
        led_next_s       = 1'b1;
        blink_cnt_next_s = CNT_ONE;
      end else if (blink_cnt_r >= BLINK_LEN) begin
        led_next_s       = ~led_r;
        blink_cnt_next_s = CNT_ONE;
      end else begin
        led_next_s       = led_r;
        blink_cnt_next_s = blink_cnt_r + CNT_ONE;
      end
    end else begin
      led_next_s       = 1'b0;
      blink_cnt_next_s = CNT_ZERO;
    end
  end

  // State, counters and all output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      dwell_r     <= CNT_ZERO;
      err_r       <= 1'b0;
      ve_r        <= 1'b0;
      ve_cnt_r    <= CNT_ZERO;
      led_r       <= 1'b0;
      blink_cnt_r <= CNT_ZERO;
      bs_r        <= 1'b0;
      vs_r        <= 1'b0;
      timeout_r   <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      dwell_r     <= dwell_next_s;
      err_r       <= err_next_s;
      ve_r        <= ve_next_s;
      ve_cnt_r    <= ve_cnt_next_s;
      led_r       <= led_next_s;
      blink_cnt_r <= blink_cnt_next_s;
      bs_r        <= (state_next_s == ST_SPRINKLE);
      vs_r        <= (state_next_s == ST_DRIP);
      if (timeout_set_s) begin
        timeout_r <= 1'b1;
      end else if (ack) begin
        timeout_r <= 1'b0;
      end else begin
        timeout_r <= timeout_r;
      end
    end
  end

  assign ve_out      = ve_r;
  assign bs_out      = bs_r;
  assign vs_out      = vs_r;
  assign alarm_led   = led_r;
  assign err_latched = err_r;
  assign state_o     = state_r;
  assign timeout     = timeout_r;

endmodule

// File: tb/tb_irrigation_actuator_sequencer.sv
// Scoreboard bench for irrigation_actuator_sequencer: a cycle model queues expected outputs per stimulus cycle.
module tb_irrigation_actuator_sequencer;

  localparam int MIN_ON  = 8;
  localparam int MIN_OFF = 4;
  localparam int BLINK   = 4;
  localparam int MAX_ON  = 64;
  localparam int SAT     = 127;
`ifdef MAX_ON_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, ve_req, bs_req, vs_req, al_in, e_in, ack;
  logic ve_out, bs_out, vs_out, alarm_led, err_latched, timeout;
  logic [2:0] state_o;

  irrigation_actuator_sequencer dut (
    .clk(clk), .rst(rst), .ve_req(ve_req), .bs_req(bs_req), .vs_req(vs_req),
    .al_in(al_in), .e_in(e_in), .ack(ack), .ve_out(ve_out), .bs_out(bs_out),
    .vs_out(vs_out), .alarm_led(alarm_led), .err_latched(err_latched),
    .state_o(state_o), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int overlap  = 0;
  logic [8:0] exp_q[$];

  // model state
  int m_state = 0, m_dwell = 0, m_vecnt = 0, m_alen = 0;
  bit m_ve = 0, m_err = 0, m_led = 0, m_to = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_step();
    int ns;
    bit flt, set_to, req, nve, nerr;
    if (rst) begin
      m_state = 0; m_dwell = 0; m_vecnt = 0; m_alen = 0;
      m_ve = 0; m_err = 0; m_led = 0; m_to = 0;
    end else begin
      flt = al_in | e_in | m_err;
      ns = m_state;
      set_to = 0;
      case (m_state)
        0: if (flt) ns = 4; else if (!m_to && bs_req) ns = 1; else if (!m_to && vs_req) ns = 2;
        1, 2: begin
          req = (m_state == 1) ? bs_req : vs_req;
          if (flt) ns = 4;
          else if (TO_EN && m_dwell >= MAX_ON - 1) begin ns = 3; set_to = 1; end
          else if (!req && m_dwell >= MIN_ON - 1) ns = 3;
        end
        3: if (flt) ns = 4; else if (m_dwell >= MIN_OFF - 1) ns = 0;
        4: if (!flt) ns = 3;
        default: ns = 0;
      endcase
      m_dwell = (ns != m_state) ? 0 : ((m_dwell < SAT) ? m_dwell + 1 : SAT);
      m_state = ns;
      nve = m_ve;
      if (e_in | m_err) nve = 0;
      else if (!m_ve && ve_req && m_vecnt >= MIN_OFF - 1) nve = 1;
      else if (m_ve && !ve_req && m_vecnt >= MIN_ON - 1) nve = 0;
      m_vecnt = (nve != m_ve) ? 0 : ((m_vecnt < SAT) ? m_vecnt + 1 : SAT);
      m_ve = nve;
      nerr = e_in ? 1'b1 : (ack ? 1'b0 : m_err);
      m_err = nerr;
      if (nerr) begin m_led = 1; m_alen = 0; end
      else if (al_in) begin m_alen++; m_led = (((m_alen - 1) / BLINK) % 2) == 0; end
      else begin m_led = 0; m_alen = 0; end
      if (set_to) m_to = 1; else if (ack) m_to = 0;
    end
    exp_q.push_back({m_state[2:0], m_ve, (m_state == 1), (m_state == 2), m_led, m_err, m_to});
  endtask

  task automatic tick();
    logic [8:0] exp_v;
    model_step();
    @(posedge clk);
    #1;
    exp_v = exp_q.pop_front();
    check_val("out_vec", {state_o, ve_out, bs_out, vs_out, alarm_led, err_latched, timeout}, {23'd0, exp_v});
    if (bs_out && vs_out) overlap++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  int cnt_a, cnt_b;
  logic [15:0] pattern;

  initial begin
    rst = 1; ve_req = 1; bs_req = 1; vs_req = 1; al_in = 0; e_in = 0; ack = 0;
    run(2);
    check_val("rst_state", state_o, 0);
    check_val("rst_outs", {ve_out, bs_out, vs_out, alarm_led, err_latched, timeout}, 0);
    rst = 0;
    tick();
    check_val("post_rst_bs", bs_out, 1);
    check_val("post_rst_state", state_o, 1);
    ve_req = 0; bs_req = 0; vs_req = 0;
    run(20);

    // single-cycle sprinkler request
    bs_req = 1;
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      bs_req = 0;
      if (bs_out) cnt_a++;
      if (state_o == 3'd3) cnt_b++;
    end
    check_val("pulse_bs_cycles", cnt_a, 8);
    check_val("pulse_cool_cycles", cnt_b, 4);
    check_val("pulse_idle", state_o, 0);

    // both requests: sprinkler wins, drip follows after cooldown
    bs_req = 1; vs_req = 1;
    cnt_a = 0;
    for (int i = 0; i < 10; i++) begin tick(); if (vs_out) cnt_a++; end
    check_val("both_sprinkle", state_o, 1);
    check_val("both_no_drip", cnt_a, 0);
    bs_req = 0;
    cnt_b = 0;
    for (int i = 0; i < 20; i++) begin tick(); if (vs_out) cnt_b++; end
    check_val("drip_follows", (cnt_b > 0), 1);
    vs_req = 0;
    run(20);

    // alarm during sprinkle at dwell 3
    bs_req = 1;
    tick();
    bs_req = 0;
    run(3);
    al_in = 1;
    tick();
    check_val("al_bs_off", bs_out, 0);
    check_val("al_fault", state_o, 4);
    pattern = {15'd0, alarm_led};
    for (int i = 0; i < 15; i++) begin tick(); pattern = {pattern[14:0], alarm_led}; end
    check_val("blink_pattern", pattern, 16'hF0F0);
    al_in = 0;
    tick();
    check_val("al_cooldown", state_o, 3);
    run(4);
    check_val("al_idle", state_o, 0);

    // error latch and inlet valve
    ve_req = 1;
    run(10);
    check_val("ve_on", ve_out, 1);
    e_in = 1;
    tick();
    e_in = 0;
    check_val("err_ve_off", ve_out, 0);
    check_val("err_set", err_latched, 1);
    check_val("err_led", alarm_led, 1);
    run(3);
    check_val("err_sticky", err_latched, 1);
    ack = 1;
    tick();
    ack = 0;
    check_val("err_ack_clr", err_latched, 0);
    e_in = 1;
    tick();
    ack = 1;
    tick();
    check_val("err_ack_with_e", err_latched, 1);
    e_in = 0;
    tick();
    ack = 0;
    check_val("err_ack_final", err_latched, 0);
    ve_req = 0;
    run(20);

`ifdef MAX_ON_TIMEOUT_EN
    vs_req = 1;
    cnt_a = 0;
    for (int i = 0; i < 90; i++) begin tick(); if (vs_out) cnt_a++; end
    check_val("to_vs_cycles", cnt_a, 64);
    check_val("to_flag", timeout, 1);
    check_val("to_no_reentry", state_o, 0);
    ack = 1;
    tick();
    ack = 0;
    tick();
    check_val("to_reentry", vs_out, 1);
    check_val("to_cleared", timeout, 0);
    vs_req = 0;
    run(80);
`endif

    // random soak against the model
    for (int i = 0; i < 400; i++) begin
      rst    = ($urandom_range(0, 99) < 1);
      ve_req = ($urandom_range(0, 99) < 40);
      bs_req = ($urandom_range(0, 99) < 20);
      vs_req = ($urandom_range(0, 99) < 25);
      al_in  = ($urandom_range(0, 99) < 4);
      e_in   = ($urandom_range(0, 99) < 2);
      ack    = ($urandom_range(0, 99) < 10);
      tick();
    end

    check_val("no_overlap", overlap, 0);
    check_val("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
